fsm_detect_scheduler: RTL and testbench

- Shares one serial "11" sequence-detector FSM among NREQ requesters.
- Each requester offers a WIDTH-bit word. A round-robin arbiter grants one requester at a time.
- The controller clears the detector, shifts the granted word in LSB-first, counts detector hits, and reports the count with a done pulse.
- Sits above the Moore/Mealy detector FSMs as their sequencer and sharing layer.

---
 rtl/fsm_sched_pkg.sv | 38 +++
 rtl/seq11_detector.sv | 58 +++++
 rtl/fsm_detect_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_fsm_detect_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_sched_pkg.sv
// Shared types and helpers for the "11" detector scheduler.
package fsm_sched_pkg;

  // Upper bounds for the round-robin search helper.
  localparam int unsigned RR_MAXREQ = 8;
  localparam int unsigned RR_IDXW   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_REPORT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DET_A,
    DET_B,
    DET_C
  } det_state_e;

  // Returns {found, index}: first set request at or after (last+1) mod nreq.
  function automatic logic [RR_IDXW:0] rr_next(input logic [RR_MAXREQ-1:0] req,
                                               input int unsigned          nreq,
                                               input logic [RR_IDXW-1:0]   last);
    logic [RR_IDXW:0] res;
    int unsigned      idx;
    res = '0;
    for (int unsigned i = 1; i <= RR_MAXREQ; i++) begin
      idx = (32'(last) + i) % nreq;
      if ((i <= nreq) && !res[RR_IDXW] && req[RR_IDXW'(idx)]) begin
        res = {1'b1, RR_IDXW'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq11_detector.sv
// Serial "11" detector. Moore A/B/C by default; define FSM_SCHED_MEALY_EN
// for the two-state Mealy variant whose z depends on the current bit.
module seq11_detector
  import fsm_sched_pkg::*;
(
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic w,
  output logic z
);

  det_state_e state;
  det_state_e state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= DET_A;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef FSM_SCHED_MEALY_EN
  // Mealy: B means the previous bit was 1; a hit is a 1 arriving in B.
  always_comb begin
    state_nxt = state;
    z         = 1'b0;
    if (clr) begin
      state_nxt = DET_A;
    end else if (w) begin
      state_nxt = DET_B;
    end else begin
      state_nxt = DET_A;
    end
    z = (state == DET_B) && w;
  end
`else
  // Moore: C means at least two consecutive 1s have been seen.
  always_comb begin
    state_nxt = state;
    z         = (state == DET_C);
    if (clr) begin
      state_nxt = DET_A;
    end else if (w) begin
      case (state)
        DET_A:   state_nxt = DET_B;
        DET_B:   state_nxt = DET_C;
        default: state_nxt = DET_C;
      endcase
    end else begin
      state_nxt = DET_A;
    end
  end
`endif

endmodule

// File: rtl/fsm_detect_scheduler.sv
// Round-robin scheduler sharing one "11" detector among NREQ requesters.
// Build option FSM_SCHED_MEALY_EN selects the Mealy detector and drops DRAIN.
module fsm_detect_scheduler
  import fsm_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ),
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       hit_count,
  output logic                  w_obs,
  output logic                  z_obs
);

  localparam int unsigned   KW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]  K_LAST  = KW'(WIDTH - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  ctrl_state_e      state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [IDW-1:0]   cur_id, cur_id_nxt;
  logic [IDW-1:0]   last, last_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             busy_nxt, done_nxt, w_nxt;
  logic [IDW-1:0]   done_id_nxt;
  logic [CNTW-1:0]  hit_count_nxt;

  logic [RR_IDXW:0] rr;
  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] pick_word;
  logic             det_clr;
  logic             det_z;

  // Shared detector, cleared while the controller is in LOAD.
  assign det_clr = (state == ST_LOAD);

  seq11_detector u_det (
    .clk   (clk),
    .Reset (Reset),
    .clr   (det_clr),
    .w     (w_obs),
    .z     (det_z)
  );

  assign z_obs   = det_z;
  assign cnt_inc = cnt + CNTW'(det_z);

  // Round-robin pick and the word belonging to the picked requester.
  always_comb begin
    rr         = rr_next(RR_MAXREQ'(req), NREQ, RR_IDXW'(last));
    pick_valid = rr[RR_IDXW];
    pick_idx   = IDW'(rr[RR_IDXW-1:0]);
    pick_word  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == pick_idx) begin
        pick_word = data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; the grant decision is made one cycle
  // ahead (idle with no pending grant, or REPORT) so gnt leaves a flop.
  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    k_nxt         = k;
    cnt_nxt       = cnt;
    cur_id_nxt    = cur_id;
    last_nxt      = last;
    gnt_nxt       = '0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    w_nxt         = 1'b0;
    done_id_nxt   = done_id;
    hit_count_nxt = hit_count;

    case (state)
      ST_IDLE: begin
        if (|gnt) begin
          state_nxt = ST_LOAD;
          busy_nxt  = 1'b1;
        end else if (pick_valid) begin
          gnt_nxt    = NREQ'(1) << pick_idx;
          sh_nxt     = pick_word;
          cur_id_nxt = pick_idx;
          last_nxt   = pick_idx;
        end
      end
      ST_LOAD: begin
        cnt_nxt   = '0;
        busy_nxt  = 1'b1;
        state_nxt = ST_SHIFT;
        w_nxt     = sh[0];
        sh_nxt    = sh >> 1;
        k_nxt     = '0;
      end
      ST_SHIFT: begin
        cnt_nxt = cnt_inc;
        if (k == K_LAST) begin
`ifdef FSM_SCHED_MEALY_EN
          state_nxt     = ST_REPORT;
          done_nxt      = 1'b1;
          done_id_nxt   = cur_id;
          hit_count_nxt = cnt_inc;
`else
          state_nxt = ST_DRAIN;
          busy_nxt  = 1'b1;
`endif
        end else begin
          busy_nxt = 1'b1;
          w_nxt    = sh[0];
          sh_nxt   = sh >> 1;
          k_nxt    = k + KW'(1);
        end
      end
`ifndef FSM_SCHED_MEALY_EN
      ST_DRAIN: begin
        cnt_nxt       = cnt_inc;
        state_nxt     = ST_REPORT;
        done_nxt      = 1'b1;
        done_id_nxt   = cur_id;
        hit_count_nxt = cnt_inc;
      end
`endif
      ST_REPORT: begin
        state_nxt = ST_IDLE;
        if (pick_valid) begin
          gnt_nxt    = NREQ'(1) << pick_idx;
          sh_nxt     = pick_word;
          cur_id_nxt = pick_idx;
          last_nxt   = pick_idx;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      sh        <= '0;
      k         <= '0;
      cnt       <= '0;
      cur_id    <= '0;
      last      <= ID_LAST;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
      w_obs     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      cur_id    <= cur_id_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      done_id   <= done_id_nxt;
      hit_count <= hit_count_nxt;
      w_obs     <= w_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_detect_scheduler.sv
// Directed bench for fsm_detect_scheduler (Moore default, or FSM_SCHED_MEALY_EN).
module tb_fsm_detect_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;
  localparam int unsigned CNTW  = 3;
`ifdef FSM_SCHED_MEALY_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 3;
`endif
  localparam int SPACING = LAT + 1;

  logic                  clk;
  logic                  Reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       hit_count;
  logic                  w_obs;
  logic                  z_obs;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0] rr_words [4] = '{8'h03, 8'h07, 8'h0F, 8'h1F};
  int               rr_hits  [4] = '{1, 2, 3, 4};

  fsm_detect_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count),
    .w_obs     (w_obs),
    .z_obs     (z_obs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_word(input int i, input logic [WIDTH-1:0] w);
    data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic wait_gnt(output int tg, output logic [31:0] g);
    bit found;
    found = 1'b0;
    tg    = 0;
    g     = '0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        found = 1'b1;
        tg    = cyc;
        g     = 32'(gnt);
      end
    end
    check("gnt_arrives", 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int tg, input logic [WIDTH-1:0] word,
                           input bit chk_w, input int exp_id, input int exp_hits);
    bit               found;
    int               td;
    logic [WIDTH-1:0] wb;
    found = 1'b0;
    td    = 0;
    wb    = '0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if ((cyc - tg >= 2) && (cyc - tg < WIDTH + 2)) wb = {w_obs, wb[WIDTH-1:1]};
      if (done) begin
        found = 1'b1;
        td    = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    check({tag, "_latency"}, 32'(td - tg), 32'(LAT));
    if (chk_w) check({tag, "_w_seq"}, 32'(wb), 32'(word));
    check({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
    check({tag, "_busy_report"}, 32'(busy), 32'd0);
  endtask

  task automatic run_job(input string tag, input int idx, input logic [WIDTH-1:0] word,
                         input int exp_hits);
    int          tg;
    logic [31:0] g;
    drive_word(idx, word);
    req[idx] = 1'b1;
    wait_gnt(tg, g);
    check({tag, "_gnt"}, g, 32'd1 << idx);
    req[idx] = 1'b0;
    @(negedge clk);
    check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
    check({tag, "_busy_load"}, 32'(busy), 32'd1);
    wait_done(tag, tg, word, 1'b1, idx, exp_hits);
  endtask

  initial begin
    int          tg;
    int          prev;
    int          bad;
    logic [31:0] g;

    Reset = 1'b1;
    req   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_w_obs", 32'(w_obs), 32'd0);
    check("rst_z_obs", 32'(z_obs), 32'd0);
    Reset = 1'b0;

    // No request: controller idles without granting.
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != '0 || busy) bad++;
    end
    check("idle_no_req", 32'(bad), 32'd0);

    // Single-requester jobs with hand-counted "11" pairs.
    run_job("w0f", 0, 8'b0000_1111, 3);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("hit_count_hold", 32'(hit_count), 32'd3);
    run_job("wff", 0, 8'hFF, 7);
    run_job("waa", 0, 8'hAA, 0);
    run_job("w66", 0, 8'b0110_0110, 2);

    // Round robin with all requesters held high from a fresh reset.
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) drive_word(i, rr_words[i]);
    req  = 4'b1111;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(tg, g);
      check("rr_gnt", g, 32'd1 << (n % 4));
      if (n > 0) check("rr_spacing", 32'(tg - prev), 32'(SPACING));
      prev = tg;
      if (n == 4) req = '0;
      wait_done("rr", tg, rr_words[n % 4], 1'b1, n % 4, rr_hits[n % 4]);
    end

    // Reset in the middle of SHIFT drops the job and the pointer.
    drive_word(0, 8'hFF);
    req[0] = 1'b1;
    wait_gnt(tg, g);
    req = '0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_w_obs", 32'(w_obs), 32'd0);
    Reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy || gnt != '0) bad++;
    end
    check("midrst_no_done", 32'(bad), 32'd0);
    drive_word(0, 8'h03);
    drive_word(1, 8'h0F);
    req = 4'b0011;
    wait_gnt(tg, g);
    check("postrst_gnt", g, 32'd1);
    req = '0;
    wait_done("postrst", tg, 8'h03, 1'b1, 0, 1);

    // Request pulsed while busy and withdrawn before IDLE is never granted.
    drive_word(0, 8'b0110_0110);
    drive_word(2, 8'hFF);
    req[0] = 1'b1;
    wait_gnt(tg, g);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    wait_done("pulse2", tg, 8'b0110_0110, 1'b0, 0, 2);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != '0) bad++;
    end
    check("pulse2_no_gnt", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
